// File: rtl/noc_packetizer.sv
// noc_packetizer: injection stage between a tile's message source and its
// local mesh router port. Turns a descriptor plus payload words into a
// wormhole packet (head flit, body flits, tail flit) through one registered
// output slot that honours router backpressure.
//
// Optional feature macro: NOC_PKT_PARITY_EN
//   defined   -> head flit bit 0 carries even parity over the whole head flit
//   undefined -> head flit bit 0 is zero
//
// state | meaning
// IDLE  | waiting for a descriptor; head (or head/tail) flit loaded on accept
// BODY  | streaming payload words; last word is tagged as tail
module noc_packetizer #(
  parameter int SRC_ID = 0,
  parameter int NODE_W = 2,
  parameter int LEN_W  = 4,
  parameter int FLIT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [NODE_W-1:0] msg_dest,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic [FLIT_W-3:0] pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  output logic [FLIT_W-1:0] flit_data_out,
  output logic              flit_valid_out,
  input  logic              flit_ready_in,
  output logic              busy
);

  typedef enum logic {IDLE, BODY} state_t;

  localparam logic [1:0] T_BODY      = 2'b00;
  localparam logic [1:0] T_HEAD      = 2'b01;
  localparam logic [1:0] T_TAIL      = 2'b10;
  localparam logic [1:0] T_HEAD_TAIL = 2'b11;
  localparam int PAD = FLIT_W - 2 - 2*NODE_W - LEN_W;
  localparam logic [NODE_W-1:0] SRC = NODE_W'(SRC_ID);

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic              load_ok;
  logic              msg_hs;
  logic              pl_hs;
  logic [1:0]        head_type;
  logic [1:0]        body_type;
  logic [FLIT_W-1:0] head_base;
  logic [FLIT_W-1:0] head_flit;

  // The slot can take a new flit when empty or being drained this cycle;
  // this keeps back-to-back packets free of bubbles.
  assign load_ok   = !flit_valid_out || flit_ready_in;
  assign msg_ready = !rst && (state == IDLE) && load_ok;
  assign pl_ready  = !rst && (state == BODY) && load_ok;
  assign busy      = (state != IDLE) || flit_valid_out;
  assign msg_hs    = msg_valid && msg_ready;
  assign pl_hs     = pl_valid && pl_ready;

  assign head_type = (msg_len == '0) ? T_HEAD_TAIL : T_HEAD;
  assign body_type = (remaining == LEN_W'(1)) ? T_TAIL : T_BODY;
  assign head_base = {head_type, msg_dest, SRC, msg_len, {PAD{1'b0}}};

`ifdef NOC_PKT_PARITY_EN
  assign head_flit = {head_base[FLIT_W-1:1], ^head_base[FLIT_W-1:1]};
`else
  assign head_flit = head_base;
`endif

  // Packet FSM and the registered output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      remaining      <= '0;
      flit_data_out  <= '0;
      flit_valid_out <= 1'b0;
    end else begin
      if (flit_valid_out && flit_ready_in)
        flit_valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (msg_hs) begin
            flit_data_out  <= head_flit;
            flit_valid_out <= 1'b1;
            remaining      <= msg_len;
            state          <= (msg_len == '0) ? IDLE : BODY;
          end
        end
        BODY: begin
          if (pl_hs) begin
            flit_data_out  <= {body_type, pl_data};
            flit_valid_out <= 1'b1;
            remaining      <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1))
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// Testbench for noc_packetizer (SRC_ID = 1). Expected flits come from a
// packet-level model: each generated packet expands into its flit list,
// which is compared against every flit the router side consumes.
module tb_noc_packetizer;

  localparam int BUDGET = 200;
  localparam logic [1:0] SRC = 2'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_valid;
  logic        msg_ready;
  logic [1:0]  msg_dest;
  logic [3:0]  msg_len;
  logic [61:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [63:0] flit_data_out;
  logic        flit_valid_out;
  logic        flit_ready_in;
  logic        busy;

  logic rdy_force = 1'b1;
  logic rdy_val   = 1'b1;
  logic rdy_rand  = 1'b1;
  assign flit_ready_in = rdy_force ? rdy_val : rdy_rand;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [63:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data  = '0;

  noc_packetizer #(.SRC_ID(1), .NODE_W(2), .LEN_W(4), .FLIT_W(64)) dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_dest(msg_dest), .msg_len(msg_len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .flit_data_out(flit_data_out), .flit_valid_out(flit_valid_out),
    .flit_ready_in(flit_ready_in), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk); #1;
      rdy_rand = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Head flit from the flit format: type, dest, source, length, zero fill.
  function automatic logic [63:0] head_model(input logic [1:0] d, input logic [3:0] l);
    logic [63:0] f;
    f = ((l == 0) ? 64'h3 : 64'h1) << 62;
    f = f + (64'(d) << 60) + (64'(SRC) << 58) + (64'(l) << 54);
`ifdef NOC_PKT_PARITY_EN
    f[0] = ^f[63:1];
`endif
    return f;
  endfunction

  function automatic logic [63:0] body_model(input logic [61:0] w, input bit last);
    return {(last ? 2'b10 : 2'b00), w};
  endfunction

  // Router-side monitor: in-order flit comparison and hold-under-stall.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(flit_valid_out), 64'd1);
        check("hold_data", flit_data_out, prev_data);
      end
      if (flit_valid_out && flit_ready_in) begin
        if (exp_q.size() == 0)
          check("unexpected_flit", flit_data_out, 64'hDEAD_0000_0000_DEAD);
        else
          check("flit_stream", flit_data_out, exp_q.pop_front());
      end
      prev_stall = flit_valid_out && !flit_ready_in;
      prev_data  = flit_data_out;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_desc(input logic [1:0] d, input logic [3:0] l, output int waits);
    bit hs;
    hs = 0;
    waits = 0;
    exp_q.push_back(head_model(d, l));
    msg_dest = d; msg_len = l; msg_valid = 1'b1;
    while (!hs && waits < BUDGET) begin
      @(negedge clk);
      hs = msg_ready;
      tick();
      if (!hs) waits++;
    end
    msg_valid = 1'b0;
    check("desc_accept", 64'(hs), 64'd1);
  endtask

  task automatic send_word(input logic [61:0] w, input bit last, input int gap, output int waits);
    bit hs;
    hs = 0;
    waits = 0;
    pl_valid = 1'b0;
    repeat (gap) tick();
    exp_q.push_back(body_model(w, last));
    pl_data = w; pl_valid = 1'b1;
    while (!hs && waits < BUDGET) begin
      @(negedge clk);
      hs = pl_ready;
      tick();
      if (!hs) waits++;
    end
    pl_valid = 1'b0;
    check("word_accept", 64'(hs), 64'd1);
  endtask

  int w;
  int t0;
  int n;
  logic [3:0]  rl;
  logic [1:0]  rd;
  logic [61:0] rw;

  initial begin
    rst = 1'b1; msg_valid = 0; msg_dest = 0; msg_len = 0; pl_data = 0; pl_valid = 0;

    // reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_msg_ready", 64'(msg_ready), 64'd0);
    check("rst_pl_ready", 64'(pl_ready), 64'd0);
    check("rst_valid", 64'(flit_valid_out), 64'd0);
    check("rst_data", flit_data_out, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_msg_ready", 64'(msg_ready), 64'd1);
    tick();

    // header-only packet
    send_desc(2'd2, 4'd0, w);
    check("ht_flit", flit_data_out, 64'hE400_0000_0000_0000);
    check("ht_valid", 64'(flit_valid_out), 64'd1);
    tick();
    check("ht_drop_valid", 64'(flit_valid_out), 64'd0);
    check("ht_busy_low", 64'(busy), 64'd0);

    // len=3 streamed packet, one flit per cycle
    send_desc(2'd3, 4'd3, w);
    t0 = cyc;
    check("s_head_type", 64'(flit_data_out[63:62]), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      send_word(62'(k), k == 3, 0, w);
      check("s_cycle", 64'(cyc - t0), 64'(k));
      check("s_type", 64'(flit_data_out[63:62]), (k == 3) ? 64'd2 : 64'd0);
      check("s_payload", 64'(flit_data_out[61:0]), 64'(k));
    end
    tick();
    check("s_idle", 64'(busy), 64'd0);

    // same packet with a 3-cycle router stall on the second flit
    send_desc(2'd3, 4'd3, w);
    send_word(62'd1, 0, 0, w);
    rdy_val = 1'b0;
    pl_data = 62'd2; pl_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_pl_ready", 64'(pl_ready), 64'd0);
      check("stall_data", flit_data_out, body_model(62'd1, 0));
      check("stall_valid", 64'(flit_valid_out), 64'd1);
      tick();
    end
    rdy_val = 1'b1;
    send_word(62'd2, 0, 0, w);
    send_word(62'd3, 1, 0, w);
    check("stall_tail", flit_data_out, body_model(62'd3, 1));
    tick();

    // back-to-back descriptors: len=1 then len=0
    send_desc(2'd0, 4'd1, w);
    t0 = cyc;
    send_word(62'h2A_5555, 1, 0, w);
    send_desc(2'd3, 4'd0, w);
    check("b2b_no_wait", 64'(w), 64'd0);
    check("b2b_cycles", 64'(cyc - t0), 64'd2);
    check("b2b_ht", flit_data_out, head_model(2'd3, 4'd0));
    tick();

    // reset after the head of a len=5 packet
    send_desc(2'd2, 4'd5, w);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_msg_ready", 64'(msg_ready), 64'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid", 64'(flit_valid_out), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_msg_ready1", 64'(msg_ready), 64'd1);
    check("mid_rst_pl_ready", 64'(pl_ready), 64'd0);
    tick();
    send_desc(2'd1, 4'd0, w);
    check("post_rst_ht", flit_data_out, head_model(2'd1, 4'd0));
    tick();

    // head parity: dest=1, len=3 gives an odd count of ones above bit 0
    send_desc(2'd1, 4'd3, w);
`ifdef NOC_PKT_PARITY_EN
    check("parity_xor", 64'(^flit_data_out), 64'd0);
    check("parity_bit0", 64'(flit_data_out[0]), 64'd1);
`else
    check("parity_bit0", 64'(flit_data_out[0]), 64'd0);
`endif
    for (int k = 1; k <= 3; k++) send_word(62'(k * 7), k == 3, 0, w);
    tick();

    // payload stall while in BODY: slot empties, packet stays open
    send_desc(2'd0, 4'd2, w);
    send_word(62'h11, 0, 0, w);
    tick();
    @(negedge clk);
    check("pstall_valid_drop", 64'(flit_valid_out), 64'd0);
    check("pstall_busy", 64'(busy), 64'd1);
    check("pstall_msg_ready", 64'(msg_ready), 64'd0);
    send_word(62'h22, 1, 2, w);
    tick();

    // randomized packets with random router backpressure and payload gaps
    rdy_force = 1'b0;
    for (int p = 0; p < 30; p++) begin
      rd = 2'($urandom_range(0, 3));
      rl = 4'($urandom_range(0, 15));
      send_desc(rd, rl, w);
      for (int k = 1; k <= int'(rl); k++) begin
        rw = {30'($urandom), 32'($urandom)};
        send_word(rw, k == int'(rl), $urandom_range(0, 2), w);
      end
    end
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
